// File: rtl/debug_pkg.sv
// debug_pkg: types shared by the debug-probe blocks.
//   DBG_WORD_W : width of one probe slot in the debug-port snapshot
//   dbg_word_t : one probe slot
package debug_pkg;

  localparam int DBG_WORD_W = 32;

  typedef logic [DBG_WORD_W-1:0] dbg_word_t;

endpackage : debug_pkg

// File: rtl/align_to_32.sv
// align_to_32: widens a WIDTH-bit debug/control field to a 32-bit probe slot.
//
// Parameters:
//   WIDTH    : bit width of `in`, legal range 1..32
//   SIGN_EXT : 0 = zero-extend, 1 = replicate in[WIDTH-1] into the upper bits
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   in        in   [WIDTH-1:0] narrow field
//   in_valid  in   qualifies `in` for the snapshot register
//   out       out  [31:0] combinational aligned word (primary output)
//   out_q     out  [31:0] aligned word captured on an in_valid edge
//   out_valid out  out_q holds a captured value (cleared only by reset)
//   changed   out  one-cycle pulse: the latest capture differs from the
//                  previously held out_q
module align_to_32
  import debug_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int SIGN_EXT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output dbg_word_t        out,
  output dbg_word_t        out_q,
  output logic             out_valid,
  output logic             changed
);

  // Extension path. Exactly one branch is elaborated, so the zero-count
  // replication that WIDTH==32 would imply is never built.
  generate
    if ((WIDTH < 1) || (WIDTH > DBG_WORD_W)) begin : g_bad_width
      $error("align_to_32: WIDTH=%0d is outside the legal range 1..32", WIDTH);
    end else if (WIDTH == DBG_WORD_W) begin : g_full
      assign out = in;
    end else if (SIGN_EXT != 0) begin : g_sign_ext
      assign out = {{(DBG_WORD_W-WIDTH){in[WIDTH-1]}}, in};
    end else begin : g_zero_ext
      assign out = {{(DBG_WORD_W-WIDTH){1'b0}}, in};
    end
  endgenerate

  // Snapshot register with valid flag and change-detect pulse. The compare
  // uses the full extended word, so sign-equivalent inputs count as equal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= {DBG_WORD_W{1'b0}};
      out_valid <= 1'b0;
      changed   <= 1'b0;
    end else if (in_valid) begin
      out_q     <= out;
      out_valid <= 1'b1;
      // First capture after reset has nothing to compare against.
      changed   <= out_valid && (out != out_q);
    end else begin
      out_q     <= out_q;
      out_valid <= out_valid;
      changed   <= 1'b0;
    end
  end

endmodule : align_to_32

// File: tb/tb_align_to_32.sv
// tb_align_to_32: self-checking bench for align_to_32.
// Five instances cover WIDTH 1, 4, 5 (sign-extended), 32 and 2. Each is
// compared against a reference that computes the extension with integer
// arithmetic and models the snapshot as a held value plus a valid flag.
module tb_align_to_32;

  localparam int N = 5;
  localparam int WID [N] = '{1, 4, 5, 32, 2};
  localparam bit SX  [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic        clk;
  logic        reset;
  logic [31:0] din  [N];
  logic        dvl  [N];
  logic [31:0] dout [N];
  logic [31:0] dq   [N];
  logic        dv   [N];
  logic        dc   [N];

  // reference state
  logic [31:0] m_q   [N];
  logic        m_v   [N];
  logic        m_chg [N];

  int n_checks;
  int n_errors;

  align_to_32 #(.WIDTH(1),  .SIGN_EXT(0)) u_w1  (.clk(clk), .reset(reset), .in(din[0][0:0]),
    .in_valid(dvl[0]), .out(dout[0]), .out_q(dq[0]), .out_valid(dv[0]), .changed(dc[0]));
  align_to_32 #(.WIDTH(4),  .SIGN_EXT(0)) u_w4  (.clk(clk), .reset(reset), .in(din[1][3:0]),
    .in_valid(dvl[1]), .out(dout[1]), .out_q(dq[1]), .out_valid(dv[1]), .changed(dc[1]));
  align_to_32 #(.WIDTH(5),  .SIGN_EXT(1)) u_w5s (.clk(clk), .reset(reset), .in(din[2][4:0]),
    .in_valid(dvl[2]), .out(dout[2]), .out_q(dq[2]), .out_valid(dv[2]), .changed(dc[2]));
  align_to_32 #(.WIDTH(32), .SIGN_EXT(0)) u_w32 (.clk(clk), .reset(reset), .in(din[3]),
    .in_valid(dvl[3]), .out(dout[3]), .out_q(dq[3]), .out_valid(dv[3]), .changed(dc[3]));
  align_to_32 #(.WIDTH(2),  .SIGN_EXT(0)) u_w2  (.clk(clk), .reset(reset), .in(din[4][1:0]),
    .in_valid(dvl[4]), .out(dout[4]), .out_q(dq[4]), .out_valid(dv[4]), .changed(dc[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value of a w-bit field as a 32-bit word: the field value itself, or for
  // a negative signed field, value - 2^w taken modulo 2^32.
  function automatic logic [31:0] ref_ext(input logic [31:0] raw, input int w, input bit sx);
    longint unsigned m, v;
    m = 64'd1 << w;
    v = longint'(raw) % m;
    if (sx && (v >= m / 64'd2))
      v = v + (64'h1_0000_0000 - m);
    return v[31:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_q[k] = 32'h0; m_v[k] = 1'b0; m_chg[k] = 1'b0;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < N; k++) begin
      check_eq($sformatf("%s_q%0d", tag, k), dq[k], m_q[k]);
      check_eq($sformatf("%s_v%0d", tag, k), {31'd0, dv[k]}, {31'd0, m_v[k]});
      check_eq($sformatf("%s_c%0d", tag, k), {31'd0, dc[k]}, {31'd0, m_chg[k]});
    end
  endtask

  // Called just after a falling edge with inputs already set: checks the
  // combinational outputs, clocks once, then checks the registered outputs.
  task automatic tick(input string tag);
    logic [31:0] e;
    #1;
    for (int k = 0; k < N; k++)
      check_eq($sformatf("%s_out%0d", tag, k), dout[k], ref_ext(din[k], WID[k], SX[k]));
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      e = ref_ext(din[k], WID[k], SX[k]);
      if (dvl[k]) begin
        m_chg[k] = m_v[k] && (e != m_q[k]);
        m_q[k]   = e;
        m_v[k]   = 1'b1;
      end else begin
        m_chg[k] = 1'b0;
      end
    end
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int k = 0; k < N; k++) begin
      din[k] = 32'h0; dvl[k] = 1'b0;
    end
    model_reset();

    // reset state
    reset = 1'b1;
    #1;
    check_regs("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // directed: first capture on every instance
    din[0] = 32'h1; din[1] = 32'hF; din[2] = 32'h10; din[3] = 32'hDEAD_BEEF; din[4] = 32'h2;
    for (int k = 0; k < N; k++) dvl[k] = 1'b1;
    #1;
    check_eq("w1_one",   dout[0], 32'h0000_0001);
    check_eq("w4_f",     dout[1], 32'h0000_000F);
    check_eq("w5_neg",   dout[2], 32'hFFFF_FFF0);
    check_eq("w32_pass", dout[3], 32'hDEAD_BEEF);
    tick("d1");
    check_eq("w32_q",    dq[3], 32'hDEAD_BEEF);
    check_eq("w32_c1",   {31'd0, dc[3]}, 32'h0);

    din[2] = 32'hF; din[4] = 32'h2;
    #1;
    check_eq("w5_pos", dout[2], 32'h0000_000F);
    tick("d2");
    check_eq("w2_c2", {31'd0, dc[4]}, 32'h0);

    din[4] = 32'h3;
    tick("d3");
    check_eq("w2_q3", dq[4], 32'h3);
    check_eq("w2_c3", {31'd0, dc[4]}, 32'h1);

    for (int k = 0; k < N; k++) dvl[k] = 1'b0;
    din[4] = 32'h1;
    tick("idle");
    check_eq("w2_hold", dq[4], 32'h3);

    // asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_regs("arst");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N; k++) dvl[k] = 1'b1;
    din[4] = 32'h3;
    tick("post_rst");

    // randomized traffic; values often repeat so unchanged captures occur
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        dvl[k] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) != 0)
          din[k] = $urandom;
        if (SX[k] && ($urandom_range(0, 3) == 0))
          din[k] = din[k] ^ 32'hFFFF_FFE0;  // same 5-bit field, different upper junk
      end
      tick("rnd");
      if ($urandom_range(0, 63) == 0) begin
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_regs("rnd_rst");
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_align_to_32
